// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops and an iterative
// shift-add unsigned multiplier, with a start/busy/done handshake.
module alu_seq_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       aluctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_MULT = 3'b111;

  typedef enum logic [0:0] {IDLE, MUL} state_t;

  state_t             state, state_n;
  logic [PW-1:0]      mcand, mcand_n;
  logic [WIDTH-1:0]   mplr, mplr_n;
  logic [PW-1:0]      acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               busy_n, done_n, zero_n, overflow_n;
  logic [WIDTH-1:0]   result_n, result_hi_n;

  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ov;
  logic [PW-1:0]      step_acc;

  assign sum      = a + b;
  assign diff     = a - b;
  assign step_acc = mplr[0] ? (acc + mcand) : acc;

  // Single-cycle datapath; SLT uses a true signed compare so it survives a-b overflow
  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    unique case (aluctr)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SUB: begin
        alu_res = diff;
        alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MULT: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    mcand_n     = mcand;
    mplr_n      = mplr;
    acc_n       = acc;
    cnt_n       = cnt;
    busy_n      = busy;
    done_n      = 1'b0;
    result_n    = result;
    result_hi_n = result_hi;
    zero_n      = zero;
    overflow_n  = overflow;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (aluctr == OP_MULT) begin
            mcand_n = PW'(a);
            mplr_n  = b;
            acc_n   = '0;
            cnt_n   = '0;
            busy_n  = 1'b1;
            state_n = MUL;
          end else begin
            result_n    = alu_res;
            result_hi_n = '0;
            zero_n      = (alu_res == '0);
            overflow_n  = alu_ov;
            done_n      = 1'b1;
          end
        end
      end
      MUL: begin
        acc_n   = step_acc;
        mcand_n = mcand << 1;
        mplr_n  = mplr >> 1;
        cnt_n   = cnt + CNT_W'(1);
        // Last step: publish the product straight from this step's sum
        if (cnt == CNT_W'(WIDTH - 1)) begin
          result_n    = step_acc[WIDTH-1:0];
          result_hi_n = step_acc[PW-1:WIDTH];
          zero_n      = (step_acc[WIDTH-1:0] == '0);
          overflow_n  = 1'b0;
          done_n      = 1'b1;
          busy_n      = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      mcand     <= mcand_n;
      mplr      <= mplr_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      result    <= result_n;
      result_hi <= result_hi_n;
      zero      <= zero_n;
      overflow  <= overflow_n;
    end
  end

endmodule
